riscv_lsu_mem_resp: RTL
=======================

Name: riscv_lsu_mem_resp

Overview:
- Responder (target) end of the core LSU peripheral port. It accepts req/we/be/addr/wdata from the LSU and returns read data one cycle later.
- Contains a byte-enabled, word-organised data RAM and a small MMIO register window:
  - 64-bit cycle counter.
  - Scratch register.
  - Error status register.
- Decodes addresses, flags accesses that hit no region, and signals read completion with a single-cycle valid pulse.

Parameters:
- XLEN, 32, data/address width; only 32 supported.
- MEM_WORDS, 1024, number of 32-bit RAM words; power of two, ≥ 4.
- MEM_BASE, 32'h0000_0000, RAM base byte address; aligned to 4*MEM_WORDS.
- MMIO_BASE, 32'h8000_0000, MMIO window base byte address; 16-byte aligned, must not overlap RAM.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous active-high reset
- lsu_req_i  in  1  access request, one-cycle strobe per access
- lsu_we_i  in  1  1 = write, 0 = read
- lsu_be_i  in  XLEN/8  byte enables
- lsu_addr_i  in  XLEN  byte address; bits [1:0] ignored for decode
- lsu_wdata_i  in  XLEN  write data, already lane-replicated by the LSU
- lsu_rdata_o  out  XLEN  read data (registered)
- lsu_rvalid_o  out  1  read completion pulse
- bus_err_o  out  1  access-error pulse, aligned with the response cycle

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values:
  - lsu_rdata_o = 0, lsu_rvalid_o = 0, bus_err_o = 0.
  - CYCLE = 0, SCRATCH = 0, ERR_CNT = 0, ERR_STICKY = 0.
  - RAM contents are not reset.
  - A read accepted in the cycle rst_i is high gets no response; a write in that cycle is not committed.
- Decode (word address A = lsu_addr_i with [1:0] cleared):
  - RAM hit: MEM_BASE ≤ A < MEM_BASE + 4*MEM_WORDS; index = (A - MEM_BASE) >> 2.
  - MMIO hit: MMIO_BASE ≤ A < MMIO_BASE + 16; offset = A[3:2].
  - Otherwise: miss.
- Write (req=1, we=1) in cycle N:
  - Every byte lane i with be[i]=1 is updated at the end of cycle N.
  - be = 0: no-op, not an error.
  - No lsu_rvalid_o for writes.
  - Miss: no state change except error accounting; bus_err_o = 1 in cycle N+1.
- Read (req=1, we=0) in cycle N:
  - lsu_rvalid_o = 1 in cycle N+1 only.
  - lsu_rdata_o holds the full 32-bit word in N+1 and keeps that value until the next read completes.
  - be is ignored; the LSU performs lane select and sign extension.
  - Miss: lsu_rdata_o = 0 in N+1, bus_err_o = 1 in N+1.
- Read-after-write: a write in N followed by a read of the same word in N+1 returns the new data in N+2. There is no same-cycle collision (single request per cycle).
- Back-to-back reads every cycle are supported at full throughput: each produces its own N+1 pulse, so lsu_rvalid_o can stay high across consecutive cycles.
- MMIO map (offset, register, access):
  - 0, CYCLE[31:0], read-only.
  - 1, CYCLE[63:32], read-only. Writes to offsets 0/1 are silently ignored, not errors.
  - 2, SCRATCH, read/write with byte enables.
  - 3, ERR_STATUS, read-only layout {ERR_STICKY, 15'b0, ERR_CNT[15:0]}. Any write with be[0]=1 clears ERR_CNT and ERR_STICKY.
- CYCLE counter:
  - 64-bit; increments by 1 every non-reset cycle; wraps 2^64-1 → 0.
  - A read returns the value at the end of cycle N, i.e. before that cycle's increment.
- Error accounting on each miss:
  - ERR_STICKY ← 1.
  - ERR_CNT ← ERR_CNT + 1, saturating at 16'hFFFF.
  - If a clear write and a miss coincide, the clear is impossible (same port, one request per cycle); a miss in the cycle after a clear counts from 0.
- Internal structure: single-port RAM with synchronous read, inferable as block RAM. The read mux selects RAM or MMIO using a decode tag registered alongside the request.

Test Plan:
- After reset, read RAM word 0x10, SCRATCH and ERR_STATUS → rvalid pulse one cycle after each read; SCRATCH = 0, ERR_STATUS = 0; rdata = 0 after reset, before any read.
- Write 0xAABBCCDD to 0x20 with be=1111, then write 0x11111111 with be=0010, then read 0x20 → rdata = 0xAABB11DD in read cycle+1, rvalid high for exactly one cycle.
- Back-to-back reads of 0x0, 0x4, 0x8 on three consecutive cycles (preloaded 1, 2, 3) → rvalid high for three consecutive cycles, rdata = 1, 2, 3.
- Read 0x4000_0000 (miss) → rdata = 0, bus_err_o = 1 in N+1. Then write to 0x4000_0004 → bus_err_o = 1; ERR_STATUS reads 0x8000_0002; write 0x1 to ERR_STATUS → reads 0.
- Read CYCLE_LO 5 cycles after reset deassertion, write 0xFFFF_FFFF to offset 0 → the write has no effect and no error; a later read is larger by the elapsed cycle count. Force CYCLE_LO = 0xFFFF_FFFF and check that CYCLE_HI increments on the wrap.
- Issue a read, assert rst_i in the next cycle → no rvalid pulse, rdata = 0, all MMIO registers back to 0.

Source files
------------

// File: rtl/riscv_lsu_mem_resp.sv
// Purpose : LSU peripheral-port responder with a byte-enabled data RAM and an MMIO window
//           (64-bit cycle counter, scratch register, error status).
// Latency : a read issued in cycle N returns data with a one-cycle rvalid pulse in N+1.
//           A write issued in cycle N commits at the end of cycle N.
// Backpr. : none. The block accepts one request every cycle, and back-to-back reads run at full rate.
//
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   lsu_req_i/we_i/be_i   request strobe, write select and byte enables
//   lsu_addr_i/wdata_i    byte address (bits [1:0] are not used for decode) and write data
//   lsu_rdata_o           read data; holds its value until the next read completes
//   lsu_rvalid_o          read completion pulse
//   bus_err_o             pulse in the response cycle of an access that hit no region
module riscv_lsu_mem_resp #(
  parameter int          XLEN      = 32,
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [XLEN/8-1:0] lsu_be_i,
  input  logic [XLEN-1:0]   lsu_addr_i,
  input  logic [XLEN-1:0]   lsu_wdata_i,
  output logic [XLEN-1:0]   lsu_rdata_o,
  output logic              lsu_rvalid_o,
  output logic              bus_err_o
);

  localparam int              AW       = $clog2(MEM_WORDS);
  localparam logic [XLEN-1:0] RAM_SPAN = XLEN'(4 * MEM_WORDS);

  // This tag records which source drives the read mux for the current response.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_MMIO = 2'd2
  } src_e;

  // ---------------- decode ----------------
  logic [XLEN-1:0] w_addr_word;
  logic            w_ram_hit;
  logic            w_mmio_hit;
  logic            w_miss;
  logic [AW-1:0]   w_ram_idx;
  logic [1:0]      w_mmio_off;
  logic            w_rd;
  logic            w_wr;

  assign w_addr_word = lsu_addr_i & ~XLEN'(3);
  // The base is aligned to the RAM size, so masking off the index bits checks the range.
  assign w_ram_hit   = (w_addr_word & ~(RAM_SPAN - XLEN'(1))) == MEM_BASE;
  assign w_mmio_hit  = w_addr_word[XLEN-1:4] == MMIO_BASE[XLEN-1:4];
  assign w_miss      = !w_ram_hit && !w_mmio_hit;
  assign w_ram_idx   = w_addr_word[AW+1:2];
  assign w_mmio_off  = w_addr_word[3:2];
  assign w_rd        = lsu_req_i && !lsu_we_i;
  assign w_wr        = lsu_req_i && lsu_we_i;

  // ---------------- RAM (single port, synchronous read, no reset) ----------------
  logic [XLEN-1:0] r_mem [MEM_WORDS];
  logic [XLEN-1:0] r_ram_q;

  always_ff @(posedge clk_i) begin
    if (w_wr && w_ram_hit && !rst_i) begin
      for (int i = 0; i < XLEN/8; i++) begin
        if (lsu_be_i[i]) r_mem[w_ram_idx][8*i +: 8] <= lsu_wdata_i[8*i +: 8];
      end
    end
    if (w_rd && w_ram_hit) r_ram_q <= r_mem[w_ram_idx];
  end

  // ---------------- MMIO registers and response state ----------------
  logic [63:0]     r_cycle;
  logic [XLEN-1:0] r_scratch;
  logic [15:0]     r_err_cnt;
  logic            r_err_sticky;
  logic [XLEN-1:0] r_mmio_q;
  src_e            r_src;
  logic            r_rvalid;
  logic            r_err;
  logic [XLEN-1:0] w_mmio_rdata;

  always_comb begin
    w_mmio_rdata = '0;
    case (w_mmio_off)
      2'd0:    w_mmio_rdata = r_cycle[31:0];
      2'd1:    w_mmio_rdata = r_cycle[63:32];
      2'd2:    w_mmio_rdata = r_scratch;
      default: w_mmio_rdata = {r_err_sticky, 15'b0, r_err_cnt};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cycle      <= '0;
      r_scratch    <= '0;
      r_err_cnt    <= '0;
      r_err_sticky <= 1'b0;
      r_mmio_q     <= '0;
      r_src        <= SRC_NONE;
      r_rvalid     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_cycle  <= r_cycle + 64'd1;
      r_rvalid <= w_rd;
      r_err    <= lsu_req_i && w_miss;

      if (w_rd) begin
        r_src <= w_ram_hit ? SRC_RAM : (w_mmio_hit ? SRC_MMIO : SRC_NONE);
        if (w_mmio_hit) r_mmio_q <= w_mmio_rdata;
      end

      if (w_wr && w_mmio_hit && w_mmio_off == 2'd2) begin
        for (int i = 0; i < XLEN/8; i++) begin
          if (lsu_be_i[i]) r_scratch[8*i +: 8] <= lsu_wdata_i[8*i +: 8];
        end
      end

      // A miss and a clear can never share a cycle: there is one request per cycle.
      if (lsu_req_i && w_miss) begin
        r_err_sticky <= 1'b1;
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
      end else if (w_wr && w_mmio_hit && w_mmio_off == 2'd3 && lsu_be_i[0]) begin
        r_err_sticky <= 1'b0;
        r_err_cnt    <= '0;
      end
    end
  end

  // Both pulses are masked while reset is high. This stops a response that was
  // already in flight from appearing in the reset cycle.
  assign lsu_rvalid_o = r_rvalid && !rst_i;
  assign bus_err_o    = r_err && !rst_i;
  assign lsu_rdata_o  = (r_src == SRC_RAM)  ? r_ram_q :
                        (r_src == SRC_MMIO) ? r_mmio_q : '0;

endmodule
